rv32m_div_unit: RTL
===================

Name: rv32m_div_unit

Overview:
Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits downstream of the 32-bit carry-lookahead adder and consumes its sum output for every trial subtraction and for the final sign correction. The multi-cycle control FSM issues a start pulse, waits for done, then writes o_result to the register file.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, because the adder sub-module is fixed at 32 bits.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  request pulse; sampled only in IDLE or DONE
i_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
i_dividend  in  32  rs1 value
i_divisor  in  32  rs2 value
o_busy  out  1  high in CALC and FIX
o_done  out  1  one-cycle pulse; o_result valid from this cycle
o_result  out  32  quotient or remainder; held until the next accepted start

Behaviour:
- Reset (async assert, any state): state IDLE; o_busy=0, o_done=0, o_result=0; all internal registers cleared. Mid-operation reset abandons the operation with no o_done.
- States: IDLE, CALC, FIX, DONE. o_done=1 only in DONE.
- E0 is the edge that samples i_start=1 in IDLE or DONE. i_start is ignored in CALC and FIX (no queueing).
- At E0, latch the following:
  - op
  - sign flags: signed = ~op[0]; neg_q = signed & (dvd[31]^dvs[31]) & (dvs!=0); neg_r = signed & dvd[31]
  - |dividend| and |divisor| when signed, raw values when unsigned
  - rem=0, count=0
- Special cases at E0: the result is loaded directly and the state goes to DONE, so o_done is high in the cycle after E0.
  - divisor==0: quotient 0xFFFFFFFF, remainder = dividend
  - signed, dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0
- Otherwise the state goes to CALC.
- CALC, one quotient bit per edge E1..E32:
  - shifted = {rem, quo[31]} (33 bits); quo shifts left.
  - Trial subtraction: cla a=shifted[31:0], b=~divisor, cin=1.
  - Carry-out is derived from bit 31, because the adder exposes no cout: co = a31&b31 | (a31^b31)&~sum31.
  - accept = shifted[32] | co. On accept: rem=sum, quo[0]=1. Otherwise: rem=shifted[31:0], quo[0]=0.
  - count increments each edge. At count==31 the state goes to FIX after E32.
- FIX (edge E33):
  - sel = op[1] ? rem : quo; neg = op[1] ? neg_r : neg_q.
  - If neg: the cla inputs are muxed to a=~sel, b=0, cin=1, and o_result gets the sum. Otherwise o_result=sel.
  - State goes to DONE.
- Latency: 34 edges. o_done is high in the cycle after E33.
- DONE lasts one cycle. It goes to IDLE, or directly to CALC/DONE if i_start=1 in that cycle (back-to-back operation, no bubble).
- Inputs are needed only at E0; they may change freely afterwards.
- Width rules:
  - All arithmetic is modulo 2^32 except the 33-bit shifted value.
  - Absolute value of 0x80000000 is 0x80000000, interpreted unsigned.

Decomposition:
- Shared package rv32m_pkg holds:
  - op encoding constants DIV/DIVU/REM/REMU
  - div_state_t enum {IDLE, CALC, FIX, DONE}
  - DIV0_QUOTIENT=32'hFFFFFFFF and INT_MIN=32'h80000000
  - DIV_ITERS=32
- Sub-module: exactly one instance of the existing cla. Its a/b/cin are muxed between trial subtraction (CALC) and negation (FIX).
- Input absolute values use plain two's-complement expressions, not a second adder.

Test Plan:
- DIVU 100/7 -> o_result 14; REMU 100/7 -> 2; o_done exactly one cycle, 34 edges after E0; o_busy high for E1..E33 cycles.
- DIV -7/2 (0xFFFFFFF9/2) -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0; each with o_done in the cycle after E0.
- DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF and DIVU 0xFFFFFFFF/0x80000001 -> 1, REMU -> 0x7FFFFFFE (exercises the 33-bit accept path and derived carry-out).
- start pulsed again at cycle 5 of CALC with different operands -> ignored, first result unchanged. start held high during DONE -> second operation accepted with no idle cycle.
- rst_n low at CALC count 10 -> o_busy/o_done/o_result 0 immediately (asynchronously). After release, DIVU 9/3 -> 3 with normal latency.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divider.
// Holds the funct3[1:0] op encodings, the divider state type and the
// fixed result constants used for the two special cases.
package rv32m_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;
    localparam int          DIV_ITERS     = 32;

endpackage

// File: rtl/rv32m_div_unit_cla.sv
// 32-bit carry-lookahead adder: sum_o = a_i + b_i + cin_i (mod 2^32).
// Eight 4-bit groups. Group generate/propagate terms are resolved by
// lookahead; bits inside a group ripple from the group carry.
// There is no carry-out port, so callers derive it from bit 31.
// Ports:
//   a_i, b_i  in  32  addends
//   cin_i     in  1   carry in
//   sum_o     out 32  sum
module rv32m_div_unit_cla (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [7:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic carry;
        logic cc;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        sum_o = '0;
        for (int j = 0; j < 8; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = &p[4*j +: 4];
        end
        carry = cin_i;
        for (int j = 0; j < 8; j++) begin
            grp_c[j] = carry;
            carry    = grp_g[j] | (grp_p[j] & carry);
        end
        for (int j = 0; j < 8; j++) begin
            cc = grp_c[j];
            for (int k = 0; k < 4; k++) begin
                sum_o[4*j+k] = p[4*j+k] ^ cc;
                cc           = g[4*j+k] | (p[4*j+k] & cc);
            end
        end
    end

endmodule

// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle on operand magnitudes, then a sign fix-up.
// A single CLA serves both the trial subtraction and the final negation.
// Ports:
//   clk         in  1   clock, rising edge
//   rst_n       in  1   async active-low reset
//   i_start     in  1   request; accepted only in IDLE or DONE
//   i_op        in  2   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend  in  32  rs1
//   i_divisor   in  32  rs2
//   o_busy      out 1   high in CALC and FIX
//   o_done      out 1   one-cycle pulse, o_result valid from here
//   o_result    out 32  quotient or remainder, held
//
// state | meaning
// IDLE  | waiting for i_start
// CALC  | 32 shift/trial-subtract steps
// FIX   | apply sign to selected result
// DONE  | result valid, may accept next start
module rv32m_div_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    div_state_t  state_q, state_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;

    logic [31:0] trial_a;
    logic [31:0] sel;
    logic        neg;
    logic [31:0] cla_a;
    logic [31:0] cla_b;
    logic [31:0] cla_sum;
    logic        co;
    logic        accept;
    logic        signed_op;
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;

    // Low 32 bits of the 33-bit {rem, quo[31]}; bit 32 is rem_q[31].
    assign trial_a = {rem_q[30:0], quo_q[31]};
    assign sel     = is_rem_q ? rem_q : quo_q;
    assign neg     = is_rem_q ? neg_rem_q : neg_quo_q;

    // FIX reuses the adder for two's-complement negation: ~sel + 0 + 1.
    assign cla_a = (state_q == FIX) ? ~sel : trial_a;
    assign cla_b = (state_q == FIX) ? 32'd0 : ~dvs_q;

    rv32m_div_unit_cla u_cla (
        .a_i   (cla_a),
        .b_i   (cla_b),
        .cin_i (1'b1),
        .sum_o (cla_sum)
    );

    // Carry out of bit 31: when a31^b31, the carry into bit 31 is ~sum31.
    assign co     = (cla_a[31] & cla_b[31]) | ((cla_a[31] ^ cla_b[31]) & ~cla_sum[31]);
    assign accept = rem_q[31] | co;

    assign signed_op = ~i_op[0];
    assign dvd_abs   = (signed_op & i_dividend[31]) ? (~i_dividend + 32'd1) : i_dividend;
    assign dvs_abs   = (signed_op & i_divisor[31])  ? (~i_divisor + 32'd1)  : i_divisor;

    always_comb begin
        state_d   = state_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            CALC: begin
                rem_d = accept ? cla_sum : trial_a;
                quo_d = {quo_q[30:0], accept};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = neg ? cla_sum : sel;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (i_start && (state_q == IDLE || state_q == DONE)) begin
            is_rem_d  = i_op[1];
            neg_quo_d = signed_op & (i_dividend[31] ^ i_divisor[31]) & (i_divisor != 32'd0);
            neg_rem_d = signed_op & i_dividend[31];
            dvs_d     = dvs_abs;
            quo_d     = dvd_abs;
            rem_d     = '0;
            cnt_d     = '0;
            if (i_divisor == 32'd0) begin
                result_d = i_op[1] ? i_dividend : DIV0_QUOTIENT;
                state_d  = DONE;
            end else if (signed_op && i_dividend == INT_MIN && i_divisor == 32'hFFFF_FFFF) begin
                result_d = i_op[1] ? 32'd0 : INT_MIN;
                state_d  = DONE;
            end else begin
                state_d  = CALC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    assign o_busy   = (state_q == CALC) || (state_q == FIX);
    assign o_done   = (state_q == DONE);
    assign o_result = result_q;

endmodule
